counter_service: RTL

COUNTER_SERVICE -- requirements
Module: counter_service

---
 rtl/queue_pkg.sv | 15 +
 rtl/counter_fsm.sv | 65 ++++++
 rtl/counter_service.sv | 79 +++++++
 3 files changed

// File: rtl/queue_pkg.sv
// queue_pkg: shared types, counter IDs and widths for the counter service block
package queue_pkg;
    typedef enum logic [1:0] {IDLE, CALLED, SERVING} state_t;
    localparam logic [2:0] CNT_NONE = 3'd0;
    localparam logic [2:0] CNT_A = 3'd1;
    localparam logic [2:0] CNT_B = 3'd2;
    localparam logic [2:0] CNT_C = 3'd3;
    localparam logic [2:0] CNT_D = 3'd4;
    localparam logic [2:0] CNT_E = 3'd5;
    localparam int NUM_W = 6;
    localparam int NUMBER_WRAP = 15;
    function automatic logic [7:0] popcount5(input logic [4:0] v);
        return {7'd0, v[0]} + {7'd0, v[1]} + {7'd0, v[2]} + {7'd0, v[3]} + {7'd0, v[4]};
    endfunction
endpackage

// File: rtl/counter_fsm.sv
// counter_fsm: one service counter's state, no-show timer and held number
module counter_fsm
    import queue_pkg::*;
#(
    parameter logic [25:0] NOSHOW_CYC = 26'd50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_call,
    input  logic [NUM_W-1:0] i_number,
    input  logic             i_arrive,
    input  logic             i_done,
    output logic             o_busy,
    output logic [NUM_W-1:0] o_num,
    output logic             o_served,
    output logic             o_noshow
);
    state_t           r_state;
    state_t           w_next;
    logic [25:0]      r_timer;
    logic [NUM_W-1:0] r_num;
    logic             w_timeout;

    assign w_timeout = r_timer == NOSHOW_CYC - 26'd1;
    assign o_busy    = r_state != IDLE;
    assign o_num     = r_num;

    // next state and completion pulses; arrive beats both done and timeout while CALLED
    always_comb begin
        w_next   = r_state;
        o_served = 1'b0;
        o_noshow = 1'b0;
        case (r_state)
            IDLE:    w_next = i_call ? CALLED : IDLE;
            CALLED: begin
                if (i_arrive) w_next = SERVING;
                else if (i_done) w_next = IDLE;
                else if (w_timeout) begin
                    w_next   = IDLE;
                    o_noshow = 1'b1;
                end
            end
            SERVING: begin
                if (i_done) begin
                    w_next   = IDLE;
                    o_served = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // state, timer (runs only while staying in CALLED) and held number
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_num   <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= (r_state == CALLED && w_next == CALLED) ? r_timer + 26'd1 : '0;
            r_num   <= (i_call && r_state == IDLE) ? i_number : (w_next == IDLE ? '0 : r_num);
        end
    end
endmodule

// File: rtl/counter_service.sv
// counter_service: call decode and statistics around five independent service counters
module counter_service
    import queue_pkg::*;
#(
    parameter logic [25:0] NOSHOW_CYC = 26'd50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       counter_call,
    input  logic [NUM_W-1:0] number_call,
    input  logic [4:0]       arrive,
    input  logic [4:0]       done,
    output logic             counterA,
    output logic             counterB,
    output logic             counterC,
    output logic             counterD,
    output logic             counterE,
    output logic [NUM_W-1:0] numA,
    output logic [NUM_W-1:0] numB,
    output logic [NUM_W-1:0] numC,
    output logic [NUM_W-1:0] numD,
    output logic [NUM_W-1:0] numE,
    output logic [NUM_W-1:0] number_service,
    output logic             call_ack,
    output logic [7:0]       served_cnt,
    output logic [7:0]       noshow_cnt
);
    logic [4:0]       w_sel;
    logic [4:0]       w_busy;
    logic [4:0]       w_served;
    logic [4:0]       w_noshow;
    logic [NUM_W-1:0] w_num [5];
    logic             r_ack;
    logic [NUM_W-1:0] r_ns;
    logic [7:0]       r_served;
    logic [7:0]       r_noshow;

    for (genvar g = 0; g < 5; g++) begin : g_cnt
        assign w_sel[g] = counter_call == CNT_A + 3'(g) && !w_busy[g];
        counter_fsm #(.NOSHOW_CYC(NOSHOW_CYC)) u_fsm (
            .clk      (clk),
            .rst      (rst),
            .i_call   (w_sel[g]),
            .i_number (number_call),
            .i_arrive (arrive[g]),
            .i_done   (done[g]),
            .o_busy   (w_busy[g]),
            .o_num    (w_num[g]),
            .o_served (w_served[g]),
            .o_noshow (w_noshow[g])
        );
    end

    assign {counterE, counterD, counterC, counterB, counterA} = w_busy;
    assign numA           = w_num[0];
    assign numB           = w_num[1];
    assign numC           = w_num[2];
    assign numD           = w_num[3];
    assign numE           = w_num[4];
    assign call_ack       = r_ack;
    assign number_service = r_ns;
    assign served_cnt     = r_served;
    assign noshow_cnt     = r_noshow;

    // acknowledge, last accepted number and completion statistics
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ack    <= 1'b0;
            r_ns     <= '0;
            r_served <= '0;
            r_noshow <= '0;
        end else begin
            r_ack    <= |w_sel;
            r_ns     <= |w_sel ? number_call : r_ns;
            r_served <= r_served + popcount5(w_served);
            r_noshow <= r_noshow + popcount5(w_noshow);
        end
    end
endmodule
